// File: rtl/mmm_nlp_pkg.sv
// Shared types and elaboration helpers for the mmm_nlp Montgomery datapath blocks.
package mmm_nlp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SUB  = 2'd2,
    DONE = 2'd3
  } montexit_st_t;

  // Bit-counter width for an IDW-iteration serial loop; at least 1 bit.
  function automatic int unsigned MMM_NLP_CNTW(input int unsigned idw);
    return (idw <= 32'd2) ? 32'd1 : $clog2(idw);
  endfunction

  // Residue and output widths must match.
  function automatic bit MMM_NLP_WIDTH_OK(input int unsigned idw, input int unsigned odw);
    return idw == odw;
  endfunction

endpackage

// File: rtl/mmm_nlp_cond_sub.sv
// Combinational conditional subtract: r = (x >= n) ? x - n : x, for x < 2n.
module mmm_nlp_cond_sub #(
  parameter int unsigned W = 256
) (
  input  logic [W:0]   x,
  input  logic [W-1:0] n,
  output logic [W-1:0] r_c
);

  logic ge_c;

  assign ge_c = (x >= {1'b0, n});
  // For x < 2n both branches are below n, so W bits hold the result.
  assign r_c  = ge_c ? W'(x - {1'b0, n}) : W'(x);

endmodule

// File: rtl/mmm_nlp_montexit.sv
// Montgomery-domain exit: bit-serial radix-2 REDC, o_r = t * 2^-IDW mod n.
// Optional input range/parity checking under `MMM_NLP_MONTEXIT_CHK_EN.
module mmm_nlp_montexit
  import mmm_nlp_pkg::*;
#(
  parameter int unsigned IDW = 256,
  parameter int unsigned ODW = 256
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_vld,
  output logic             o_rdy,
  input  logic [2*IDW-1:0] i_t,
  input  logic [IDW-1:0]   i_n,
  output logic             o_vld,
  input  logic             i_rdy,
  output logic [ODW-1:0]   o_r,
  output logic             o_err
);

  localparam int unsigned TW = 2 * IDW + 1;
  localparam int unsigned CW = MMM_NLP_CNTW(IDW);

  if (!MMM_NLP_WIDTH_OK(IDW, ODW)) begin : g_width_chk
    $error("mmm_nlp_montexit: ODW must equal IDW");
  end

  montexit_st_t   state_q, state_d;
  logic [TW-1:0]  t_q, t_d;
  logic [IDW-1:0] n_q, n_d;
  logic [IDW-1:0] r_q, r_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           vld_q, vld_d;
  logic           rdy_q, rdy_d;
  logic [TW-1:0]  sum_c;
  logic [IDW-1:0] sub_r_c;

  // T + N cannot overflow TW bits because T < N * 2^IDW on entry.
  assign sum_c = t_q + TW'(n_q);

  mmm_nlp_cond_sub #(.W(IDW)) u_cond_sub (
    .x   (t_q[IDW:0]),
    .n   (n_q),
    .r_c (sub_r_c)
  );

`ifdef MMM_NLP_MONTEXIT_CHK_EN
  logic err_q, err_d;
  logic chk_bad_c;

  assign chk_bad_c = (~i_n[0]) | (i_n <= IDW'(1)) | (i_t[2*IDW-1:IDW] >= i_n);
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    n_d     = n_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    rdy_d   = rdy_q;
`ifdef MMM_NLP_MONTEXIT_CHK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (i_vld) begin
          t_d     = {1'b0, i_t};
          n_d     = i_n;
          cnt_d   = '0;
          rdy_d   = 1'b0;
          state_d = RUN;
`ifdef MMM_NLP_MONTEXIT_CHK_EN
          err_d   = chk_bad_c;
          if (chk_bad_c) state_d = SUB;
`endif
        end
      end
      RUN: begin
        t_d   = t_q[0] ? (sum_c >> 1) : (t_q >> 1);
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(IDW - 1)) state_d = SUB;
      end
      SUB: begin
        r_d = sub_r_c;
`ifdef MMM_NLP_MONTEXIT_CHK_EN
        if (err_q) r_d = '0;
`endif
        vld_d   = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (i_rdy) begin
          vld_d   = 1'b0;
          rdy_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      t_q     <= '0;
      n_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b1;
`ifdef MMM_NLP_MONTEXIT_CHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      n_q     <= n_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      rdy_q   <= rdy_d;
`ifdef MMM_NLP_MONTEXIT_CHK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign o_rdy = rdy_q;
  assign o_vld = vld_q;
  assign o_r   = ODW'(r_q);
`ifdef MMM_NLP_MONTEXIT_CHK_EN
  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

endmodule
